// File: rtl/period_chk_pkg.sv
// Shared types and default constants for the tick period checker.
package period_chk_pkg;

  // Default configuration of the checker.
  localparam int unsigned DEF_NOM_PERIOD = 2501;
  localparam int unsigned DEF_TOL        = 4;
  localparam int unsigned DEF_LOCK_CNT   = 3;
  localparam int unsigned DEF_IW         = 12;

  // Width of the free-running tick counter output.
  localparam int unsigned TICK_CNT_W = 16;

  // Checker state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = (max_val < 2) ? 1 : unsigned'($clog2(max_val + 1));
    return w;
  endfunction

endpackage

// File: rtl/period_chk_ivl.sv
// Interval counter for the period checker: counts cycles since the last tick,
// saturating at the upper window edge, and classifies each tick against the
// acceptance window. The classification outputs are combinational.
module period_chk_ivl
  import period_chk_pkg::*;
#(
  parameter int unsigned NOM_PERIOD = DEF_NOM_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned IW         = DEF_IW
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  output logic good_c_o,
  output logic early_c_o,
  output logic timeout_c_o
);

  localparam logic [IW-1:0] IC_LO = IW'(NOM_PERIOD - TOL);
  localparam logic [IW-1:0] IC_HI = IW'(NOM_PERIOD + TOL);

  logic [IW-1:0] ic_q;
  logic [IW-1:0] ic_d;

  // Reload on a tick so the value seen at the next tick equals the gap.
  always_comb begin
    ic_d = ic_q;
    if (tick_i) begin
      ic_d = IW'(1);
    end else if (ic_q < IC_HI) begin
      ic_d = ic_q + IW'(1);
    end
  end

  // Interval counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_q <= '0;
    end else begin
      ic_q <= ic_d;
    end
  end

  // Window classification of the current cycle.
  always_comb begin
    good_c_o    = tick_i && (ic_q >= IC_LO) && (ic_q <= IC_HI);
    early_c_o   = tick_i && (ic_q < IC_LO);
    timeout_c_o = !tick_i && (ic_q == IC_HI);
  end

endmodule

// File: rtl/period_checker.sv
// Tick period checker: acquires lock after LOCK_CNT consecutive in-window
// intervals, flags early ticks and missing ticks, and counts all ticks.
// Build option: PERIOD_CHK_AUTO_RECOVER_EN lets a tick move FAULT back to
// acquisition; without it FAULT is left only by clr_fault_i or reset.
module period_checker
  import period_chk_pkg::*;
#(
  parameter int unsigned NOM_PERIOD = DEF_NOM_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
  parameter int unsigned IW         = DEF_IW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_i,
  input  logic                  clr_fault_i,
  output logic                  locked_o,
  output logic                  fault_o,
  output logic                  early_o,
  output logic                  miss_o,
  output logic [TICK_CNT_W-1:0] tick_cnt_o
);

  localparam int unsigned GW = cnt_width(LOCK_CNT);

  state_e                  state_q;
  state_e                  state_d;
  logic [GW-1:0]           good_q;
  logic [GW-1:0]           good_d;
  logic                    early_q;
  logic                    early_d;
  logic                    miss_q;
  logic                    miss_d;
  logic [TICK_CNT_W-1:0]   tick_cnt_q;
  logic                    good_c;
  logic                    early_c;
  logic                    timeout_c;

  period_chk_ivl #(
    .NOM_PERIOD (NOM_PERIOD),
    .TOL        (TOL),
    .IW         (IW)
  ) u_ivl (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_i),
    .good_c_o    (good_c),
    .early_c_o   (early_c),
    .timeout_c_o (timeout_c)
  );

  // State and good-interval count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      ST_IDLE: begin
        // First tick only starts the interval measurement.
        if (tick_i) begin
          state_d = ST_ACQ;
          good_d  = '0;
        end
      end
      ST_ACQ: begin
        if (good_c) begin
          if (good_q >= GW'(LOCK_CNT - 1)) begin
            state_d = ST_LOCK;
            good_d  = GW'(LOCK_CNT);
          end else begin
            good_d = good_q + GW'(1);
          end
        end else if (early_c) begin
          good_d = '0;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      end
      ST_LOCK: begin
        if (early_c || timeout_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
`ifdef PERIOD_CHK_AUTO_RECOVER_EN
        // Clear wins over a coincident tick.
        if (clr_fault_i) begin
          state_d = ST_IDLE;
          good_d  = '0;
        end else if (tick_i) begin
          state_d = ST_ACQ;
          good_d  = '0;
        end
`else
        if (clr_fault_i) begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase
  end

  // Early/miss events are reported only while tracking the period.
  always_comb begin
    early_d = 1'b0;
    miss_d  = 1'b0;
    if ((state_q == ST_ACQ) || (state_q == ST_LOCK)) begin
      early_d = early_c;
      miss_d  = timeout_c;
    end
  end

  // Event pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      early_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      early_q <= early_d;
      miss_q  <= miss_d;
    end
  end

  // Total tick count, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick_i) begin
      tick_cnt_q <= tick_cnt_q + TICK_CNT_W'(1);
    end
  end

  assign locked_o   = (state_q == ST_LOCK);
  assign fault_o    = (state_q == ST_FAULT);
  assign early_o    = early_q;
  assign miss_o     = miss_q;
  assign tick_cnt_o = tick_cnt_q;

endmodule

// File: tb/tb_period_checker.sv
// Directed testbench for period_checker with default parameters.
module tb_period_checker;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        clr_fault;
  logic        locked;
  logic        fault;
  logic        early;
  logic        miss;
  logic [15:0] tick_cnt;

  int n_checks;
  int n_errors;
  int exp_tc;

  period_checker #(
    .NOM_PERIOD (2501),
    .TOL        (4),
    .LOCK_CNT   (3),
    .IW         (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick),
    .clr_fault_i (clr_fault),
    .locked_o    (locked),
    .fault_o     (fault),
    .early_o     (early),
    .miss_o      (miss),
    .tick_cnt_o  (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; sample point is just after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    exp_tc++;
  endtask

  // Tick so that its distance to the previous tick is gap cycles.
  task automatic gap_tick(input int gap);
    step(gap - 1);
    pulse_tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_early"}, 32'(early), 32'd0);
    check({tag, "_miss"}, 32'(miss), 32'd0);
    check({tag, "_tick_cnt"}, 32'(tick_cnt), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_tc    = 0;
    rst       = 1'b1;
    tick      = 1'b1;
    clr_fault = 1'b0;

    // Reset with a coincident tick: tick must not be counted.
    step(3);
    check_all_zero("reset");
    rst  = 1'b0;
    tick = 1'b0;
    step(2);
    check("post_reset_cnt", 32'(tick_cnt), 32'd0);

    // Acquire: IDLE tick, then three good intervals.
    pulse_tick();
    check("acq_first_cnt", 32'(tick_cnt), 32'd1);
    gap_tick(2501);
    gap_tick(2501);
    check("acq_third_locked", 32'(locked), 32'd0);
    step(2500);
    check("acq_pre4_locked", 32'(locked), 32'd0);
    pulse_tick();
    check("lock_rise", 32'(locked), 32'd1);
    check("lock_fault", 32'(fault), 32'd0);
    check("lock_cnt", 32'(tick_cnt), 32'd4);

    // Early tick while locked.
    gap_tick(2490);
    check("early_pulse", 32'(early), 32'd1);
    check("early_fault", 32'(fault), 32'd1);
    check("early_locked", 32'(locked), 32'd0);
    check("early_miss", 32'(miss), 32'd0);
    step(1);
    check("early_drop", 32'(early), 32'd0);
    check("early_cnt", 32'(tick_cnt), 32'(exp_tc));

`ifdef PERIOD_CHK_AUTO_RECOVER_EN
    // A tick leaves FAULT for acquisition; three good intervals relock.
    gap_tick(2500);
    check("ar_fault", 32'(fault), 32'd0);
    check("ar_locked", 32'(locked), 32'd0);
    gap_tick(2501);
    gap_tick(2501);
    check("ar_two_locked", 32'(locked), 32'd0);
    gap_tick(2501);
    check("ar_relock", 32'(locked), 32'd1);
`else
    // Good ticks do not clear a fault, and are still counted.
    gap_tick(2500);
    gap_tick(2501);
    check("sticky_fault", 32'(fault), 32'd1);
    check("sticky_early", 32'(early), 32'd0);
    check("sticky_cnt", 32'(tick_cnt), 32'(exp_tc));
    step(10);
    clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_locked", 32'(locked), 32'd0);
    pulse_tick();
    gap_tick(2501);
    gap_tick(2501);
    check("clr_two_locked", 32'(locked), 32'd0);
    gap_tick(2501);
    check("clr_relock", 32'(locked), 32'd1);
`endif

    // clr_fault while locked has no effect; then ticks stop.
    clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    check("clr_in_lock", 32'(locked), 32'd1);
    step(2503);
    check("pre_miss", 32'(miss), 32'd0);
    check("pre_miss_locked", 32'(locked), 32'd1);
    step(1);
    check("miss_pulse", 32'(miss), 32'd1);
    check("miss_fault", 32'(fault), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
    step(1);
    check("miss_drop", 32'(miss), 32'd0);
    step(5);
    check("miss_quiet", 32'(miss), 32'd0);

    // Reset in FAULT beats coincident tick and clr_fault.
    rst       = 1'b1;
    tick      = 1'b1;
    clr_fault = 1'b1;
    step(1);
    rst       = 1'b0;
    tick      = 1'b0;
    clr_fault = 1'b0;
    exp_tc    = 0;
    check_all_zero("rst_fault");

    // ACQ: early resets good count; window edges 2497 and 2505 are good.
    step(7);
    pulse_tick();
    gap_tick(2501);
    gap_tick(2496);
    check("acq_early_pulse", 32'(early), 32'd1);
    check("acq_early_fault", 32'(fault), 32'd0);
    check("acq_early_locked", 32'(locked), 32'd0);
    gap_tick(2497);
    gap_tick(2505);
    check("acq_two_locked", 32'(locked), 32'd0);
    gap_tick(2501);
    check("acq_relock", 32'(locked), 32'd1);
    check("acq_cnt", 32'(tick_cnt), 32'(exp_tc));

    // Reset 1000 cycles into a locked interval.
    step(999);
    check("mid_locked", 32'(locked), 32'd1);
    rst = 1'b1;
    step(1);
    rst    = 1'b0;
    exp_tc = 0;
    check_all_zero("rst_mid");

    // Relock, then window edges in LOCK.
    step(3);
    pulse_tick();
    gap_tick(2501);
    gap_tick(2501);
    gap_tick(2501);
    check("l2_locked", 32'(locked), 32'd1);
    gap_tick(2497);
    check("l2_2497_locked", 32'(locked), 32'd1);
    check("l2_2497_early", 32'(early), 32'd0);
    gap_tick(2505);
    check("l2_2505_locked", 32'(locked), 32'd1);
    check("l2_2505_fault", 32'(fault), 32'd0);
    gap_tick(2496);
    check("l2_2496_early", 32'(early), 32'd1);
    check("l2_2496_fault", 32'(fault), 32'd1);
    check("l2_cnt", 32'(tick_cnt), 32'(exp_tc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/period_checker.md
PERIOD_CHECKER -- requirements
Module: period_checker

Interface
REQ-001 SHALL have parameter NOM_PERIOD, default 2501, nominal cycles between consecutive tick pulses.
REQ-002 SHALL have parameter TOL, default 4, allowed +/- deviation in cycles.
REQ-003 SHALL have parameter LOCK_CNT, default 3, consecutive good intervals required to lock.
REQ-004 SHALL have parameter IW, default 12, interval counter width; requires NOM_PERIOD+TOL < 2**IW.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 tick  in  1  one-cycle periodic pulse from the upstream delay stage.
REQ-008 clr_fault  in  1  clears FAULT state.
REQ-009 locked  out  1  high while state is LOCK.
REQ-010 fault  out  1  high while state is FAULT.
REQ-011 early  out  1  one-cycle pulse: a tick arrived with interval < NOM_PERIOD-TOL.
REQ-012 miss  out  1  one-cycle pulse: no tick by interval NOM_PERIOD+TOL.
REQ-013 tick_cnt  out  16  total ticks seen since reset.

Function
REQ-014 Interval counter ic SHALL load 1 on a tick cycle, else increment, saturating at NOM_PERIOD+TOL; ticks at t0 and t1 give ic = t1-t0 at t1.
REQ-015 Interval is good iff NOM_PERIOD-TOL <= ic <= NOM_PERIOD+TOL when sampled on a tick.
REQ-016 Miss event SHALL occur in ACQ or LOCK when ic == NOM_PERIOD+TOL and tick == 0.
REQ-017 Early event SHALL occur in ACQ or LOCK on a tick with ic < NOM_PERIOD-TOL.
REQ-018 States IDLE, ACQ, LOCK, FAULT; next-state registered.
REQ-019 IDLE: tick -> ACQ, good count = 0; no interval check on that tick.
REQ-020 ACQ: good tick -> good count+1, -> LOCK when it reaches LOCK_CNT; early -> stay ACQ, good count = 0; miss -> IDLE.
REQ-021 LOCK: good tick -> stay; early or miss -> FAULT.
REQ-022 FAULT: behaviour per REQ-031/032; ic keeps running; early/miss not reported.
REQ-023 locked/fault SHALL be decoded from the state register; locked rises the cycle after the LOCK_CNT-th good tick.
REQ-024 early/miss SHALL be registered, high exactly the cycle after the event.
REQ-025 tick_cnt SHALL increment on every tick in every state, wrapping 16'hFFFF -> 0.
REQ-026 clr_fault outside FAULT SHALL have no effect.

Reset
REQ-027 On rst: state IDLE, ic 0, good count 0, locked 0, fault 0, early 0, miss 0, tick_cnt 0.
REQ-028 rst SHALL take priority over tick and clr_fault in the same cycle, including mid-interval and in FAULT.
REQ-029 A tick coincident with rst SHALL be ignored (not counted).

Configuration
REQ-030 Macro PERIOD_CHK_AUTO_RECOVER_EN selects fault exit.
REQ-031 Defined: FAULT + tick -> ACQ, good count 0, ic = 1; clr_fault also -> IDLE; simultaneous clr_fault and tick -> IDLE.
REQ-032 Undefined: FAULT sticky; only clr_fault (-> IDLE) or rst exits; ticks still counted.

Structure
REQ-033 Package period_chk_pkg SHALL hold the state enum and default parameter constants.
REQ-034 Sub-module period_chk_ivl SHALL implement the saturating interval counter and in-window/early/timeout compares.

Verification (NOM_PERIOD=2501, TOL=4, LOCK_CNT=3)
REQ-035 Ticks every 2501 cycles from reset -> locked rises the cycle after the 4th tick; fault stays 0; tick_cnt = 4.
REQ-036 Locked, next tick gap 2490 -> early pulse 1 cycle after that tick; fault = 1, locked = 0.
REQ-037 Locked, ticks stop -> miss pulse 2506 cycles after last tick (ic = 2505); state FAULT.
REQ-038 In FAULT without macro: ticks at 2501 persist fault; clr_fault -> IDLE next cycle; re-locks after 4 further ticks.
REQ-039 With PERIOD_CHK_AUTO_RECOVER_EN: in FAULT, tick -> ACQ; 3 good intervals -> locked.
REQ-040 rst asserted 1000 cycles into a locked interval -> all outputs 0 next cycle; gaps of 2497 and 2505 accepted, 2496 early.
